// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bit(s).
// One clock per bit period; tx_out and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  ready,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [DATA_WIDTH-1:0] data_q, data_next, shifted;
  logic                  par_en_q, par_en_next;
  logic                  par_q, par_next;
  logic                  tx_q, tx_next;
  logic                  busy_q, busy_next;
  logic                  accept;

  // Handshake: ready is combinational from state only; a frame is taken at
  // any posedge where data_valid & ready. data_valid with ready low is dropped.

  always_ff @(posedge clk_based_on_prescale) begin
    if (asy_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      data_q   <= data_next;
      par_en_q <= par_en_next;
      par_q    <= par_next;
      tx_q     <= tx_next;
      busy_q   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    data_next   = data_q;
    par_en_next = par_en_q;
    par_next    = par_q;
    if (accept) begin
      data_next   = p_data;
      par_en_next = parity_enable;
      par_next    = (^p_data) ^ parity_type;
    end
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        state_next = DATA;
        cnt_next   = '0;
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          cnt_next   = '0;
          state_next = par_en_q ? PARITY : STOP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PARITY: begin
        state_next = STOP;
        cnt_next   = '0;
      end
      STOP: begin
        if (cnt == STOP_LAST) begin
          cnt_next   = '0;
          state_next = accept ? START : IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The registered line level is chosen from the state being entered, so
  // the start bit shows on tx_out at the accept edge itself.
  always_comb begin
    ready     = (state == IDLE) || ((state == STOP) && (cnt == STOP_LAST));
    accept    = data_valid && ready;
    shifted   = data_next >> cnt_next;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shifted[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (8 data/1 stop and 7 data/2 stop)
// share stimulus and are compared every cycle against a line-bit queue model.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       dv;
  logic       pe;
  logic       pt;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;

  int checks;
  int errors;

  // Each queue holds the line bits still to be shown; element 0 is on the line now.
  logic exp_a_q[$];
  logic exp_b_q[$];

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
    .clk_based_on_prescale(clk),
    .asy_reset            (rst),
    .p_data               (p_data),
    .data_valid           (dv),
    .parity_enable        (pe),
    .parity_type          (pt),
    .ready                (ready_a),
    .tx_out               (tx_a),
    .busy                 (busy_a)
  );

  uart_tx_frame #(.DATA_WIDTH(7), .STOP_BITS(2)) dut_b (
    .clk_based_on_prescale(clk),
    .asy_reset            (rst),
    .p_data               (p_data[6:0]),
    .data_valid           (dv),
    .parity_enable        (pe),
    .parity_type          (pt),
    .ready                (ready_b),
    .tx_out               (tx_b),
    .busy                 (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole frame as a bit vector, bit 0 sent first.
  function automatic logic [12:0] frame_vec(input int dw, input int stops,
                                            input logic [8:0] d, input logic en,
                                            input logic odd, output int len);
    logic [12:0] v;
    int pos;
    int ones;
    v    = '1;
    v[0] = 1'b0;
    pos  = 1;
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      v[pos[3:0]] = d[i[3:0]];
      ones += d[i[3:0]] ? 1 : 0;
      pos++;
    end
    if (en) begin
      v[pos[3:0]] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      pos++;
    end
    len = pos + stops;
    return v;
  endfunction

  // One bit period: check ready, advance the model at the edge, check the line.
  task automatic cycle();
    logic        acc_a, acc_b;
    logic [12:0] v;
    int          len;
    check("ready_a", ready_a, exp_a_q.size() <= 1);
    check("ready_b", ready_b, exp_b_q.size() <= 1);
    acc_a = dv && (exp_a_q.size() <= 1);
    acc_b = dv && (exp_b_q.size() <= 1);
    @(posedge clk);
    if (rst) begin
      exp_a_q.delete();
      exp_b_q.delete();
    end else begin
      if (exp_a_q.size() > 0) void'(exp_a_q.pop_front());
      if (exp_b_q.size() > 0) void'(exp_b_q.pop_front());
      if (acc_a) begin
        v = frame_vec(8, 1, {1'b0, p_data}, pe, pt, len);
        for (int i = 0; i < len; i++) exp_a_q.push_back(v[i[3:0]]);
      end
      if (acc_b) begin
        v = frame_vec(7, 2, {2'b00, p_data[6:0]}, pe, pt, len);
        for (int i = 0; i < len; i++) exp_b_q.push_back(v[i[3:0]]);
      end
    end
    @(negedge clk);
    check("tx_a",   tx_a,   exp_a_q.size() > 0 ? exp_a_q[0] : 1'b1);
    check("busy_a", busy_a, exp_a_q.size() > 0);
    check("tx_b",   tx_b,   exp_b_q.size() > 0 ? exp_b_q[0] : 1'b1);
    check("busy_b", busy_b, exp_b_q.size() > 0);
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic odd);
    p_data = d;
    pe     = en;
    pt     = odd;
    dv     = 1'b1;
    cycle();
    dv     = 1'b0;
  endtask

  logic seq_a5[11];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    dv     = 1'b0;
    p_data = '0;
    pe     = 1'b0;
    pt     = 1'b0;
    seq_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset, then idle
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_tx", tx_a, 1'b1);
    end

    // 0xA5, even parity: fixed 11-bit pattern
    send(8'hA5, 1'b1, 1'b0);
    check("a5_seq", tx_a, seq_a5[0]);
    for (int i = 1; i < 11; i++) begin
      cycle();
      check("a5_seq", tx_a, seq_a5[i]);
    end
    cycle();
    check("a5_idle_busy", busy_a, 1'b0);

    // Parity slot for 0x01: odd -> 0, even -> 1; then no parity slot
    send(8'h01, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) cycle();
    check("par_odd_01", tx_a, 1'b0);
    cycle();
    cycle();
    send(8'h01, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) cycle();
    check("par_even_01", tx_a, 1'b1);
    cycle();
    cycle();
    send(8'h01, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) cycle();
    check("nopar_stop", tx_a, 1'b1);
    cycle();
    check("nopar_len10", busy_a, 1'b0);

    // Back-to-back frames with data_valid held high
    p_data = 8'h55;
    pe     = 1'b0;
    pt     = 1'b0;
    dv     = 1'b1;
    cycle();
    p_data = 8'hAA;
    for (int k = 1; k < 20; k++) begin
      cycle();
      if (k == 10) begin
        check("b2b_start2", tx_a, 1'b0);
        dv = 1'b0;
      end
      check("b2b_busy", busy_a, 1'b1);
    end
    cycle();
    check("b2b_done", busy_a, 1'b0);

    // Mid-frame data_valid is dropped
    send(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    p_data = 8'hFF;
    dv     = 1'b1;
    check("mid_ready", ready_a, 1'b0);
    cycle();
    dv = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Reset during data bit 3, then a clean frame
    send(8'h96, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle();
    rst = 1'b1;
    cycle();
    check("rst_tx", tx_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    rst = 1'b0;
    cycle();
    send(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      dv     = ($urandom_range(0, 2) == 0);
      p_data = 8'($urandom_range(0, 255));
      pe     = 1'($urandom_range(0, 1));
      pt     = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 1'b0;
    dv  = 1'b0;
    for (int i = 0; i < 15; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
